// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register block.
package i2c_target_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    // Level the target leaves on SDA during an acknowledge slot
    localparam logic SDA_ACK  = 1'b0;
    localparam logic SDA_NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT
    } state_e;

endpackage

// File: rtl/i2c_target_sync.sv
// Synchronises SCL/SDA and turns them into one-cycle bus event pulses.
module i2c_target_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_lvl_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    // [0],[1] form the synchroniser, [2] is the delayed copy for edge detection
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // Shift pins through the synchroniser; idle bus is high on both lines
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    // Registered event pulses, aligned with the sampled SDA level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sda_lvl_o  <= 1'b1;
            scl_rise_o <= 1'b0;
            scl_fall_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
        end else begin
            sda_lvl_o  <= sda_q[1];
            scl_rise_o <= scl_q[1] & ~scl_q[2];
            scl_fall_o <= ~scl_q[1] & scl_q[2];
            start_o    <= scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
            stop_o     <= scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
        end
    end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a small 8-bit register file: pointer write, burst write, burst read.
module i2c_target_regs
    import i2c_target_pkg::*;
#(
    parameter logic [6:0]  TargetAddr = 7'h50,
    parameter int unsigned NumRegs    = 16,
    parameter int unsigned HoldCycles = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       scl_i,
    input  logic                       sda_i,
    output logic                       sda_o,
    output logic                       sda_en_o,
    input  logic [$clog2(NumRegs)-1:0] dbg_addr_i,
    output logic [7:0]                 dbg_data_o,
    output logic                       wr_pulse_o,
    output logic                       busy_o
);

    localparam int unsigned AW = $clog2(NumRegs);
    localparam int unsigned HW = (HoldCycles < 1) ? 1 : $clog2(HoldCycles + 1);
    localparam logic [BIT_CNT_W-1:0] BIT_MSB = 3'd7;

    logic sda_lvl, scl_rise, scl_fall, start_ev, stop_ev;

    i2c_target_sync u_sync (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_lvl_o  (sda_lvl),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_ev),
        .stop_o     (stop_ev)
    );

    state_e                state_q, state_d;
    logic [BIT_CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [BYTE_W-1:0]     shift_q, shift_d;
    logic [AW-1:0]         ptr_q, ptr_d;
    logic                  rw_q, rw_d;
    logic                  busy_q, busy_d;
    logic                  pend_q, pend_d;
    logic                  hold_load_c, rel_now_c, wr_en_c;
    logic [BYTE_W-1:0]     rx_byte_c;

    logic [HW-1:0]         hold_cnt_q;
    logic                  hold_act_q;
    logic                  sda_en_q;
    logic                  wr_pulse_q;
    logic [BYTE_W-1:0]     regs_q [NumRegs];

    assign rx_byte_c = {shift_q[BYTE_W-2:0], sda_lvl};

    // FSM state and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= BIT_MSB;
            shift_q  <= '0;
            ptr_q    <= '0;
            rw_q     <= 1'b0;
            busy_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            rw_q     <= rw_d;
            busy_q   <= busy_d;
            pend_q   <= pend_d;
        end
    end

    // Next state: START/STOP win over bit events; drive targets are staged in pend_d
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        busy_d      = busy_q;
        pend_d      = pend_q;
        hold_load_c = 1'b0;
        rel_now_c   = 1'b0;
        wr_en_c     = 1'b0;

        if (stop_ev) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            pend_d    = 1'b0;
            rel_now_c = 1'b1;
        end else if (start_ev) begin
            state_d     = ST_ADDR;
            bitcnt_d    = BIT_MSB;
            pend_d      = 1'b0;
            hold_load_c = 1'b1;
        end else if (scl_fall) begin
            hold_load_c = 1'b1;
            case (state_q)
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: pend_d = 1'b1;
                ST_RD_DATA: begin
                    if (bitcnt_q == BIT_MSB) begin
                        shift_d = regs_q[ptr_q];
                        pend_d  = ~regs_q[ptr_q][BYTE_W-1];
                    end else begin
                        pend_d  = ~shift_q[bitcnt_q];
                    end
                end
                default: pend_d = 1'b0;
            endcase
        end else if (scl_rise) begin
            case (state_q)
                ST_ADDR: begin
                    shift_d = rx_byte_c;
                    if (bitcnt_q == '0) begin
                        if (rx_byte_c[7:1] == TargetAddr) begin
                            state_d = ST_ADDR_ACK;
                            busy_d  = 1'b1;
                            rw_d    = rx_byte_c[0];
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q - 3'd1;
                    end
                end
                ST_ADDR_ACK: begin
                    state_d  = rw_q ? ST_RD_DATA : ST_PTR;
                    bitcnt_d = BIT_MSB;
                end
                ST_PTR: begin
                    shift_d = rx_byte_c;
                    if (bitcnt_q == '0) begin
                        if ({1'b0, rx_byte_c} < 9'(NumRegs)) begin
                            ptr_d   = AW'(rx_byte_c);
                            state_d = ST_PTR_ACK;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q - 3'd1;
                    end
                end
                ST_PTR_ACK, ST_WR_ACK: begin
                    state_d  = ST_WR_DATA;
                    bitcnt_d = BIT_MSB;
                end
                ST_WR_DATA: begin
                    shift_d = rx_byte_c;
                    if (bitcnt_q == '0) begin
                        wr_en_c = 1'b1;
                        ptr_d   = ptr_q + AW'(1);
                        state_d = ST_WR_ACK;
                    end else begin
                        bitcnt_d = bitcnt_q - 3'd1;
                    end
                end
                ST_RD_DATA: begin
                    if (bitcnt_q == '0) begin
                        ptr_d   = ptr_q + AW'(1);
                        state_d = ST_RD_ACK;
                    end else begin
                        bitcnt_d = bitcnt_q - 3'd1;
                    end
                end
                ST_RD_ACK: begin
                    if (sda_lvl == SDA_ACK) begin
                        state_d  = ST_RD_DATA;
                        bitcnt_d = BIT_MSB;
                    end else begin
                        state_d  = ST_WAIT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Hold timer: apply the staged SDA drive HoldCycles after the event; STOP releases at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_cnt_q <= '0;
            hold_act_q <= 1'b0;
            sda_en_q   <= 1'b0;
        end else if (rel_now_c) begin
            hold_cnt_q <= '0;
            hold_act_q <= 1'b0;
            sda_en_q   <= 1'b0;
        end else if (hold_load_c) begin
            hold_cnt_q <= HW'(HoldCycles);
            hold_act_q <= 1'b1;
        end else if (hold_act_q) begin
            if (hold_cnt_q == '0) begin
                sda_en_q   <= pend_q;
                hold_act_q <= 1'b0;
            end else begin
                hold_cnt_q <= hold_cnt_q - HW'(1);
            end
        end
    end

    // Register file write port and write strobe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            wr_pulse_q <= 1'b0;
        end else begin
            wr_pulse_q <= wr_en_c;
            if (wr_en_c) begin
                regs_q[ptr_q] <= rx_byte_c;
            end
        end
    end

    assign sda_o      = 1'b0;
    assign sda_en_o   = sda_en_q;
    assign wr_pulse_o = wr_pulse_q;
    assign busy_o     = busy_q;
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: a bit-banged I2C host against i2c_target_regs on a wired-AND SDA.
module tb_i2c_target_regs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       host_sda;
    logic       sda_o;
    logic       sda_en;
    logic       wr_pulse;
    logic       busy;
    logic [3:0] dbg_addr;
    logic [7:0] dbg_data;
    wire        sda_bus = host_sda & ~sda_en;

    int n_pass  = 0;
    int n_total = 0;
    int wr_cnt  = 0;

    i2c_target_regs dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .scl_i      (scl),
        .sda_i      (sda_bus),
        .sda_o      (sda_o),
        .sda_en_o   (sda_en),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .wr_pulse_o (wr_pulse),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // Count cycles with the write strobe high
    always @(negedge clk) if (wr_pulse) wr_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic peek(input int idx, output logic [7:0] v);
        dbg_addr = 4'(idx);
        #1;
        v = dbg_data;
    endtask

    task automatic write_bit(input logic b);
        wait_clk(5);  host_sda = b;
        wait_clk(15); scl = 1'b1;
        wait_clk(20); scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_clk(5);  host_sda = 1'b1;
        wait_clk(15); scl = 1'b1;
        wait_clk(10); b = sda_bus;
        wait_clk(10); scl = 1'b0;
    endtask

    task automatic i2c_start();
        host_sda = 1'b1; scl = 1'b1;
        wait_clk(10); host_sda = 1'b0;
        wait_clk(10); scl = 1'b0;
    endtask

    task automatic i2c_rstart();
        wait_clk(5);  host_sda = 1'b1;
        wait_clk(15); scl = 1'b1;
        wait_clk(10); host_sda = 1'b0;
        wait_clk(10); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(5);  host_sda = 1'b0;
        wait_clk(15); scl = 1'b1;
        wait_clk(10); host_sda = 1'b1;
        wait_clk(10);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic host_ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) read_bit(b[i]);
        write_bit(host_ack);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        int bad;
        rst_n = 1'b0; scl = 1'b1; host_sda = 1'b1; dbg_addr = '0;
        wait_clk(5);
        n_total++;
        if ({sda_o, sda_en, wr_pulse, busy} !== 4'b0000)
            $display("FAIL reset_outputs: got sda_o/en/wr/busy=%b want 0000", {sda_o, sda_en, wr_pulse, busy});
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            peek(i, v);
            if (v !== 8'h00) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL reset_regs: %0d nonzero registers, want 0", bad);
        else n_pass++;
        rst_n = 1'b1;
        wait_clk(5);
    endtask

    task automatic test_write();
        logic [3:0] acks;
        logic [7:0] v;
        int w0;
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, acks[3]);
        n_total++;
        if (busy !== 1'b1) $display("FAIL wr_busy_set: got %b want 1", busy);
        else n_pass++;
        write_byte(8'h03, acks[2]);
        write_byte(8'hA5, acks[1]);
        write_byte(8'h3C, acks[0]);
        i2c_stop();
        n_total++;
        if (acks !== 4'b0000) $display("FAIL wr_acks: got %b want 0000", acks);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL wr_busy_clear: got %b want 0", busy);
        else n_pass++;
        peek(3, v);
        n_total++;
        if (v !== 8'hA5) $display("FAIL wr_reg3: got %h want a5", v);
        else n_pass++;
        peek(4, v);
        n_total++;
        if (v !== 8'h3C) $display("FAIL wr_reg4: got %h want 3c", v);
        else n_pass++;
        n_total++;
        if (wr_cnt - w0 !== 2) $display("FAIL wr_pulses: got %0d want 2", wr_cnt - w0);
        else n_pass++;
    endtask

    task automatic test_read();
        logic [6:0] acks;
        logic [7:0] d0, d1, d2;
        // Seed regs[5] so the final pointer can be observed on the bus
        i2c_start();
        write_byte(8'hA0, acks[6]);
        write_byte(8'h05, acks[5]);
        write_byte(8'h5A, acks[4]);
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, acks[3]);
        write_byte(8'h03, acks[2]);
        i2c_rstart();
        write_byte(8'hA1, acks[1]);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        i2c_stop();
        i2c_start();
        write_byte(8'hA1, acks[0]);
        read_byte(1'b1, d2);
        i2c_stop();
        n_total++;
        if (acks !== 7'b0000000) $display("FAIL rd_acks: got %b want 0000000", acks);
        else n_pass++;
        n_total++;
        if (d0 !== 8'hA5) $display("FAIL rd_byte0: got %h want a5", d0);
        else n_pass++;
        n_total++;
        if (d1 !== 8'h3C) $display("FAIL rd_byte1: got %h want 3c", d1);
        else n_pass++;
        n_total++;
        if (d2 !== 8'h5A) $display("FAIL rd_ptr_after: got %h want 5a (ptr=5)", d2);
        else n_pass++;
    endtask

    task automatic test_addr_mismatch();
        logic a0, a1, b_seen;
        logic [7:0] v;
        int w0;
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'hA2, a0);
        b_seen = busy;
        write_byte(8'h00, a1);
        i2c_stop();
        n_total++;
        if ({a0, a1} !== 2'b11) $display("FAIL mm_nack: got %b want 11", {a0, a1});
        else n_pass++;
        n_total++;
        if (b_seen !== 1'b0) $display("FAIL mm_busy: got %b want 0", b_seen);
        else n_pass++;
        peek(3, v);
        n_total++;
        if (v !== 8'hA5 || wr_cnt != w0) $display("FAIL mm_regs: reg3=%h writes=%0d want a5/0", v, wr_cnt - w0);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [3:0] acks;
        logic [1:0] nacks;
        logic [7:0] v;
        int w0;
        i2c_start();
        write_byte(8'hA0, acks[3]);
        write_byte(8'h0F, acks[2]);
        write_byte(8'h11, acks[1]);
        write_byte(8'h22, acks[0]);
        i2c_stop();
        n_total++;
        if (acks !== 4'b0000) $display("FAIL wrap_acks: got %b want 0000", acks);
        else n_pass++;
        peek(15, v);
        n_total++;
        if (v !== 8'h11) $display("FAIL wrap_reg15: got %h want 11", v);
        else n_pass++;
        peek(0, v);
        n_total++;
        if (v !== 8'h22) $display("FAIL wrap_reg0: got %h want 22", v);
        else n_pass++;
        // Out-of-range pointer: NACK then the rest of the transfer is ignored
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, acks[0]);
        write_byte(8'h10, nacks[1]);
        write_byte(8'h99, nacks[0]);
        i2c_stop();
        n_total++;
        if ({acks[0], nacks} !== 3'b011) $display("FAIL badptr_acks: got %b want 011", {acks[0], nacks});
        else n_pass++;
        peek(1, v);
        n_total++;
        if (v !== 8'h00 || wr_cnt != w0) $display("FAIL badptr_nowrite: reg1=%h writes=%0d want 00/0", v, wr_cnt - w0);
        else n_pass++;
    endtask

    task automatic test_partial_stop();
        logic [4:0] acks;
        logic [7:0] v;
        int w0;
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, acks[4]);
        write_byte(8'h07, acks[3]);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        i2c_stop();
        peek(7, v);
        n_total++;
        if (v !== 8'h00 || wr_cnt != w0 || busy !== 1'b0)
            $display("FAIL partial_discard: reg7=%h writes=%0d busy=%b want 00/0/0", v, wr_cnt - w0, busy);
        else n_pass++;
        i2c_start();
        write_byte(8'hA0, acks[2]);
        write_byte(8'h07, acks[1]);
        write_byte(8'h42, acks[0]);
        i2c_stop();
        peek(7, v);
        n_total++;
        if (acks !== 5'b00000 || v !== 8'h42)
            $display("FAIL partial_recover: acks=%b reg7=%h want 00000/42", acks, v);
        else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        logic [4:0] acks;
        logic b7;
        logic [7:0] v;
        int bad;
        i2c_start();
        write_byte(8'hA0, acks[4]);
        write_byte(8'h03, acks[3]);
        i2c_rstart();
        write_byte(8'hA1, acks[2]);
        read_bit(b7);
        wait_clk(12);
        // Second bit of A5 is 0, so the target must be pulling SDA low now
        n_total++;
        if ({b7, sda_en, busy} !== 3'b111) $display("FAIL rst_pre: bit7/sda_en/busy=%b want 111", {b7, sda_en, busy});
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({sda_en, busy} !== 2'b00) $display("FAIL rst_async: sda_en/busy=%b want 00", {sda_en, busy});
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            peek(i, v);
            if (v !== 8'h00) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL rst_regs: %0d nonzero registers, want 0", bad);
        else n_pass++;
        scl = 1'b1; host_sda = 1'b1;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);
        i2c_start();
        write_byte(8'hA0, acks[1]);
        write_byte(8'h02, acks[0]);
        write_byte(8'h99, acks[0]);
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, acks[0]);
        write_byte(8'h02, acks[0]);
        i2c_rstart();
        write_byte(8'hA1, acks[0]);
        read_byte(1'b1, v);
        i2c_stop();
        n_total++;
        if (acks !== 5'b00000 || v !== 8'h99) $display("FAIL rst_fresh: acks=%b read=%h want 00000/99", acks, v);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_mismatch();
        test_wrap();
        test_partial_stop();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
